// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store unit controller.
// Holds the request type encodings, the controller state enum, the
// default RAM word-address width and the access-size decode.
package lsu_pkg;

  localparam int MEM_AW_DEF = 15;

  typedef enum logic [2:0] {
    RW_B  = 3'b000,
    RW_H  = 3'b001,
    RW_W  = 3'b010,
    RW_BU = 3'b100,
    RW_HU = 3'b101
  } rw_type_t;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    MERGE,
    WRITE,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } lane_sz_t;

  // Anything that is not a legal sub-word access is handled as a full word.
  // Unsigned types are legal for loads only, so a store with type[2]=1
  // degrades to a word store.
  function automatic lane_sz_t access_size(input logic [2:0] rw_type, input logic we);
    lane_sz_t sz;
    case (rw_type)
      RW_B:    sz = SZ_B;
      RW_H:    sz = SZ_H;
      RW_BU:   sz = we ? SZ_W : SZ_B;
      RW_HU:   sz = we ? SZ_W : SZ_H;
      default: sz = SZ_W;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/lsu_lane_mux.sv
// lsu_lane_mux: combinational byte-lane logic for the LSU.
// Extracts and sign/zero-extends a byte or half from a RAM word for loads,
// and merges store data into the addressed lane of a RAM word for stores.
// Halves use off[1] only; words ignore the offset.
module lsu_lane_mux
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Lane select, extension and store merge.
  always_comb begin
    case (off)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h     = off[1] ? rdata[31:16] : rdata[15:0];
    load_data  = rdata;
    store_word = wdata;
    case (size)
      SZ_B: begin
        load_data  = {{24{sext & lane_b[7]}}, lane_b};
        store_word = rdata;
        store_word[{off, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_H: begin
        load_data  = {{16{sext & lane_h[15]}}, lane_h};
        store_word = rdata;
        store_word[{off[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store controller in front of a word RAM
// with one-cycle read latency. Sub-word stores are read-modify-write.
// Optional feature macro: LSU_MISALIGN_CHK_EN enables misalignment and
// illegal-type detection (resp_err); without it resp_err stays 0 and
// offsets are truncated to the access size.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_AW = MEM_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_type,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t      state;
  logic        we_q;
  logic [2:0]  type_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  lane_sz_t    acc_size;
  lane_sz_t    cur_size;
  logic        acc_err;
  logic [31:0] load_data;
  logic [31:0] store_word;
  logic        unused_addr;

  assign acc_size    = access_size(req_type, req_we);
  assign cur_size    = access_size(type_q, we_q);
  assign unused_addr = ^addr_q[31:MEM_AW+2];

`ifdef LSU_MISALIGN_CHK_EN
  logic acc_illegal;
  logic acc_misalign;

  // Classify the incoming request as illegal or misaligned.
  always_comb begin
    acc_illegal  = (req_type == 3'b011) || (req_type == 3'b110) ||
                   (req_type == 3'b111) || (req_we && req_type[2]);
    acc_misalign = ((req_type[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_type == RW_W) && (req_addr[1:0] != 2'b00));
  end

  assign acc_err = acc_illegal | acc_misalign;
`else
  assign acc_err = 1'b0;
`endif

  lsu_lane_mux u_lane_mux (
    .size       (cur_size),
    .sext       (~type_q[2]),
    .off        (addr_q[1:0]),
    .rdata      (mem_rdata),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // RAM strobes decode from state; reset masks them so a WRITE cut by reset never lands.
  assign req_ready = (state == IDLE);
  assign mem_en    = ((state == READ) || (state == WRITE)) & ~rst;
  assign mem_we    = (state == WRITE) & ~rst;
  assign mem_addr  = addr_q[MEM_AW+1:2];
  assign mem_wdata = wdata_q;

  // Request FSM: capture, optional read, lane merge, optional write, response pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      type_q     <= 3'b000;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            type_q  <= req_type;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            if (acc_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= 32'd0;
              resp_err   <= 1'b1;
            end else if (req_we && (acc_size == SZ_W)) begin
              state <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end
        READ: state <= MERGE;
        MERGE: begin
          if (we_q) begin
            wdata_q <= store_word;
            state   <= WRITE;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= load_data;
            resp_err   <= 1'b0;
          end
        end
        WRITE: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_rdata <= 32'd0;
          resp_err   <= 1'b0;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: table-driven scoreboard bench for lsu_ctrl with a word RAM model.
`timescale 1ns/1ps
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_type;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_en;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  lsu_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_type   (req_type),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Word RAM, one-cycle read latency, preloaded while init_mem is high.
  logic [31:0] mem [0:32767];
  logic        init_mem;
  always @(posedge clk) begin
    if (init_mem) begin
      mem[4]  <= 32'h8899AABB;
      mem[5]  <= 32'h80FF7F01;
      mem[6]  <= 32'h11223344;
      mem[8]  <= 32'h00000000;
      mem[9]  <= 32'hDEADBEEF;
      mem[10] <= 32'h00000000;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  typedef struct {
    logic        we;
    logic [2:0]  typ;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          en;
    logic        wr;
    logic [31:0] wword;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          en;
    logic        wr;
    logic [31:0] wword;
    int          acc;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];
  exp_t mon_e;

  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          en_cnt = 0;
  int          we_total = 0;
  int          last_we_cyc = -1;
  logic [31:0] last_we_data = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t ld(input logic [2:0] typ, input logic [31:0] addr, input logic [31:0] rdata);
    vec_t v;
    v = '{we: 1'b0, typ: typ, addr: addr, wdata: 32'd0, rdata: rdata, err: 1'b0,
          lat: 3, en: 1, wr: 1'b0, wword: 32'd0};
    return v;
  endfunction

  function automatic vec_t st(input logic [2:0] typ, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] wword, input int lat, input int en);
    vec_t v;
    v = '{we: 1'b1, typ: typ, addr: addr, wdata: wdata, rdata: 32'd0, err: 1'b0,
          lat: lat, en: en, wr: 1'b1, wword: wword};
    return v;
  endfunction

  function automatic vec_t er(input logic we, input logic [2:0] typ, input logic [31:0] addr, input logic [31:0] wdata);
    vec_t v;
    v = '{we: we, typ: typ, addr: addr, wdata: wdata, rdata: 32'd0, err: 1'b1,
          lat: 1, en: 0, wr: 1'b0, wword: 32'd0};
    return v;
  endfunction

  // Response monitor: pops the scoreboard on each resp_valid pulse.
  always @(negedge clk) begin
    if (mem_en === 1'b1) en_cnt = en_cnt + 1;
    if (mem_we === 1'b1) begin
      we_total     = we_total + 1;
      last_we_cyc  = cyc;
      last_we_data = mem_wdata;
    end
    if (resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: resp_valid=1 with nothing outstanding (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        if (!mon_e.err) chk("resp_rdata", resp_rdata, mon_e.rdata);
        chk("resp_err", {31'd0, resp_err}, {31'd0, mon_e.err});
        chk("latency", cyc - mon_e.acc, mon_e.lat);
        chk("mem_en_cycles", en_cnt, mon_e.en);
        if (mon_e.wr) begin
          chk("write_data", last_we_data, mon_e.wword);
          chk("write_cycle", last_we_cyc, mon_e.acc + mon_e.lat - 1);
        end
      end
      en_cnt = 0;
    end
  end

  task automatic send(input vec_t v);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: req_ready=%b required 1", req_ready);
      return;
    end
    req_valid = 1'b1;
    req_we    = v.we;
    req_type  = v.typ;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    e = '{rdata: v.rdata, err: v.err, lat: v.lat, en: v.en, wr: v.wr, wword: v.wword, acc: cyc};
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: addr %h got no response, required one", v.addr);
      sb.delete();
    end
    @(negedge clk);
    @(negedge clk);
    chk("hold_valid", {31'd0, resp_valid}, 32'd0);
    chk("hold_err", {31'd0, resp_err}, {31'd0, v.err});
    if (!v.err) chk("hold_rdata", resp_rdata, v.rdata);
  endtask

  int we_before;

  initial begin
    rst       = 1'b1;
    init_mem  = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_type  = 3'b000;
    req_addr  = 32'd0;
    req_wdata = 32'd0;

    vt.push_back(ld(3'b000, 32'h11, 32'hFFFFFFAA));
    vt.push_back(ld(3'b101, 32'h12, 32'h00008899));
    vt.push_back(ld(3'b100, 32'h11, 32'h000000AA));
    vt.push_back(ld(3'b001, 32'h12, 32'hFFFF8899));
    vt.push_back(ld(3'b010, 32'h10, 32'h8899AABB));
    vt.push_back(ld(3'b000, 32'h10, 32'hFFFFFFBB));
    vt.push_back(ld(3'b000, 32'h13, 32'hFFFFFF88));
    vt.push_back(ld(3'b001, 32'h14, 32'h00007F01));
    vt.push_back(ld(3'b101, 32'h16, 32'h000080FF));
    vt.push_back(ld(3'b001, 32'h16, 32'hFFFF80FF));
    vt.push_back(ld(3'b000, 32'h15, 32'h0000007F));
    vt.push_back(st(3'b000, 32'h13, 32'h00000055, 32'h5599AABB, 4, 2));
    vt.push_back(ld(3'b010, 32'h10, 32'h5599AABB));
    vt.push_back(st(3'b001, 32'h1A, 32'hFFFFCAFE, 32'hCAFE3344, 4, 2));
    vt.push_back(ld(3'b010, 32'h18, 32'hCAFE3344));
    vt.push_back(st(3'b010, 32'h20, 32'h12345678, 32'h12345678, 2, 1));
    vt.push_back(ld(3'b010, 32'h20, 32'h12345678));
`ifdef LSU_MISALIGN_CHK_EN
    vt.push_back(er(1'b0, 3'b010, 32'h22, 32'd0));
    vt.push_back(er(1'b0, 3'b001, 32'h11, 32'd0));
    vt.push_back(er(1'b0, 3'b011, 32'h10, 32'd0));
    vt.push_back(er(1'b1, 3'b100, 32'h24, 32'hA5A5A577));
    vt.push_back(ld(3'b010, 32'h24, 32'hDEADBEEF));
    vt.push_back(er(1'b0, 3'b110, 32'h14, 32'd0));
`else
    vt.push_back(ld(3'b010, 32'h22, 32'h12345678));
    vt.push_back(ld(3'b001, 32'h11, 32'hFFFFAABB));
    vt.push_back(ld(3'b011, 32'h10, 32'h5599AABB));
    vt.push_back(st(3'b100, 32'h24, 32'hA5A5A577, 32'hA5A5A577, 2, 1));
    vt.push_back(ld(3'b010, 32'h24, 32'hA5A5A577));
    vt.push_back(ld(3'b110, 32'h14, 32'h80FF7F01));
`endif
    vt.push_back(st(3'b000, 32'h14, 32'hFFFFFF12, 32'h80FF7F12, 4, 2));
    vt.push_back(ld(3'b100, 32'h14, 32'h00000012));

    repeat (3) @(posedge clk);
    #1;
    init_mem = 1'b0;

    // Reset state, both during and just after reset.
    @(negedge clk);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset_rdata", resp_rdata, 32'd0);
    chk("reset_err", {31'd0, resp_err}, 32'd0);
    chk("idle_mem_en", {31'd0, mem_en}, 32'd0);

    foreach (vt[i]) send(vt[i]);

    // Word store cut by reset in its WRITE cycle.
    we_before = we_total;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_type  = 3'b010;
    req_addr  = 32'h28;
    req_wdata = 32'hCAFEBABE;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    chk("write_rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("write_rst_mem_en", {31'd0, mem_en}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("after_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("after_rst_writes", we_total - we_before, 32'd0);
    chk("after_rst_mem", mem[10], 32'd0);
    chk("after_rst_rdata", resp_rdata, 32'd0);
    chk("after_rst_err", {31'd0, resp_err}, 32'd0);
    en_cnt = 0;
    send(ld(3'b010, 32'h28, 32'h00000000));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000ns");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter MEM_AW, default 15: RAM word-address width.
REQ-002 SHALL have port clk, input, 1: sole clock, all state on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port req_valid, input, 1: request present.
REQ-005 SHALL have port req_ready, output, 1: request accepted when req_valid&req_ready.
REQ-006 SHALL have port req_we, input, 1: 1=store, 0=load.
REQ-007 SHALL have port req_type, input, 3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-008 SHALL have port req_addr, input, 32: byte address.
REQ-009 SHALL have port req_wdata, input, 32: store data, right-aligned.
REQ-010 SHALL have port resp_valid, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata, output, 32: extended load data; 0 for stores.
REQ-012 SHALL have port resp_err, output, 1: misaligned or illegal type, valid with resp_valid.
REQ-013 SHALL have ports mem_en (out, 1), mem_we (out, 1), mem_addr (out, MEM_AW), mem_wdata (out, 32), mem_rdata (in, 32): word RAM with one-cycle read latency.

Function
REQ-014 SHALL use FSM states IDLE, READ, MERGE, WRITE, RESP; req_ready=1 only in IDLE.
REQ-015 SHALL capture req_we/type/addr/wdata into registers on accept.
REQ-016 SHALL, on accept: error -> RESP; load or byte/half store -> READ; word store -> WRITE.
REQ-017 SHALL in READ drive mem_en=1, mem_we=0, mem_addr=addr_q[MEM_AW+1:2]; next MERGE.
REQ-018 SHALL in MERGE sample mem_rdata; load: select lane by addr_q[1:0], sign-extend (type[2]=0) or zero-extend (type[2]=1), register, go RESP; store: merge byte/half into lane, register word, go WRITE.
REQ-019 SHALL in WRITE drive mem_en=1, mem_we=1, same mem_addr, mem_wdata=merged or full word; next RESP.
REQ-020 SHALL in RESP assert resp_valid for exactly one cycle, then return to IDLE; no backpressure.
REQ-021 SHALL give latency from accept cycle T: error T+1, word store T+2, load T+3, byte/half store T+4.
REQ-022 SHALL drive mem_en=0, mem_we=0 in IDLE, MERGE, RESP; no RAM access for errored requests.
REQ-023 SHALL flag misaligned: half with addr[0]=1, word with addr[1:0]!=0; illegal: type 011, 110, 111, or store with type[2]=1.
REQ-024 SHALL hold resp_rdata/resp_err at last value when resp_valid=0.

Reset
REQ-025 SHALL on rst: state IDLE, resp_valid 0, resp_rdata 0, resp_err 0, all captured registers 0.
REQ-026 SHALL gate mem_en and mem_we with ~rst so no RAM write occurs in any reset cycle, including reset during WRITE.
REQ-027 SHALL abandon any in-flight request on reset with no resp_valid.

Configuration
REQ-028 SHALL with LSU_MISALIGN_CHK_EN defined implement REQ-023 error detection.
REQ-029 SHALL without LSU_MISALIGN_CHK_EN tie resp_err 0, truncate offsets (half uses addr[1], word ignores addr[1:0]), treat illegal types as word.

Structure
REQ-030 SHALL place rw_type encodings, FSM state enum and MEM_AW default in package lsu_pkg.
REQ-031 SHALL place lane extract/extend and store merge in combinational sub-module lsu_lane_mux.

Verification
REQ-032 SHALL check: mem[0x10>>2]=0x8899AABB, lb addr 0x11 -> resp_rdata 0xFFFFFFAA at T+3, resp_err 0.
REQ-033 SHALL check: same word, lhu addr 0x12 -> resp_rdata 0x00008899.
REQ-034 SHALL check: sb 0x55 to addr 0x13 over 0x8899AABB -> write 0x5599AABB at T+3, resp_valid T+4.
REQ-035 SHALL check: sw 0x12345678 addr 0x20 -> mem_we at T+1 addr 8, resp_valid T+2, no read cycle.
REQ-036 SHALL check: lw addr 0x22 with macro -> resp_err 1 at T+1, mem_en never asserted; without macro -> word at addr 8 returned.
REQ-037 SHALL check: rst asserted in WRITE cycle -> no mem_we, no resp_valid, req_ready 1 after release.
